// File: rtl/ansi_pkg.sv
// Shared constants for the ANSI input decoder: key codes, byte values, FSM states
// and small byte-classification helpers.
package ansi_pkg;

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_SPACE = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_LEFT  = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_CHAR  = 3'd7;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_O        = 8'h4F;
  localparam logic [7:0] ASCII_SEMI     = 8'h3B;
  localparam logic [7:0] ASCII_R        = 8'h52;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2,
    ST_SS3  = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_arrow(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h44);
  endfunction

  function automatic logic [2:0] arrow_code(input logic [7:0] b);
    logic [2:0] code;
    case (b)
      8'h41:   code = KEY_UP;
      8'h42:   code = KEY_DOWN;
      8'h43:   code = KEY_RIGHT;
      8'h44:   code = KEY_LEFT;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ansi_param_acc.sv
// Saturating decimal accumulator for one CSI parameter; seen flags that at least
// one digit arrived since the last clear.
module ansi_param_acc
  import ansi_pkg::*;
#(
  parameter int PARAM_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       dig_stb,
  input  logic [3:0] dig,
  output logic [7:0] value,
  output logic       seen
);

  logic [7:0]  value_q, value_d;
  logic        seen_q, seen_d;
  logic [11:0] sum;

  always_comb begin
    // value_q <= 255 so value*10 + 9 always fits in 12 bits before saturating
    sum     = 12'(value_q) * 12'd10 + 12'(dig);
    value_d = value_q;
    seen_d  = seen_q;
    if (clr) begin
      value_d = '0;
      seen_d  = 1'b0;
    end else if (dig_stb) begin
      value_d = (sum > 12'(PARAM_MAX)) ? 8'(PARAM_MAX) : sum[7:0];
      seen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      seen_q  <= seen_d;
    end
  end

  assign value = value_q;
  assign seen  = seen_q;

endmodule

// File: rtl/ansi_input_decoder.sv
// Turns the raw terminal byte stream into key events and cursor position reports
// (plain chars, CSI arrows/CPR, SS3 arrows, lone ESC with idle timeout).
module ansi_input_decoder
  import ansi_pkg::*;
#(
  parameter int ESC_TIMEOUT = 4,
  parameter int PARAM_MAX   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       key_valid,
  output logic [2:0] key_code,
  output logic [7:0] key_char,
  output logic       cpr_valid,
  output logic [7:0] cpr_row,
  output logic [7:0] cpr_col,
  output logic       err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ESC_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       idx_q, idx_d;
  logic       key_valid_q, key_valid_d;
  logic [2:0] key_code_q, key_code_d;
  logic [7:0] key_char_q, key_char_d;
  logic       cpr_valid_q, cpr_valid_d;
  logic [7:0] cpr_row_q, cpr_row_d;
  logic [7:0] cpr_col_q, cpr_col_d;
  logic       err_q, err_d;

  logic       acc_clr;
  logic       dig_stb0, dig_stb1;
  logic [7:0] p0, p1;
  logic       seen0, seen1;

  ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .dig_stb (dig_stb0),
    .dig     (in_data[3:0]),
    .value   (p0),
    .seen    (seen0)
  );

  ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .dig_stb (dig_stb1),
    .dig     (in_data[3:0]),
    .value   (p1),
    .seen    (seen1)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    key_valid_d = 1'b0;
    key_code_d  = KEY_NONE;
    key_char_d  = 8'h00;
    cpr_valid_d = 1'b0;
    cpr_row_d   = cpr_row_q;
    cpr_col_d   = cpr_col_q;
    err_d       = 1'b0;
    acc_clr     = 1'b0;
    dig_stb0    = 1'b0;
    dig_stb1    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_data == ASCII_ESC) begin
            state_d = ST_ESC;
            timer_d = '0;
          end else if (in_data == ASCII_SPACE) begin
            key_valid_d = 1'b1;
            key_code_d  = KEY_SPACE;
            key_char_d  = ASCII_SPACE;
          end else if (in_data >= 8'h21 && in_data <= 8'h7E) begin
            key_valid_d = 1'b1;
            key_code_d  = KEY_CHAR;
            key_char_d  = in_data;
          end
        end
      end

      ST_ESC: begin
        if (in_valid) begin
          if (in_data == ASCII_LBRACKET) begin
            state_d = ST_CSI;
            idx_d   = 1'b0;
            acc_clr = 1'b1;
          end else if (in_data == ASCII_O) begin
            state_d = ST_SS3;
          end else if (in_data == ASCII_ESC) begin
            key_valid_d = 1'b1;
            key_code_d  = KEY_ESC;
            timer_d     = '0;
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = KEY_ESC;
            err_d       = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          key_valid_d = 1'b1;
          key_code_d  = KEY_ESC;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_CSI: begin
        if (in_valid) begin
          if (is_digit(in_data)) begin
            dig_stb0 = !idx_q;
            dig_stb1 = idx_q;
          end else if (in_data == ASCII_SEMI) begin
            if (!idx_q) begin
              idx_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (is_arrow(in_data)) begin
            key_valid_d = 1'b1;
            key_code_d  = arrow_code(in_data);
            state_d     = ST_IDLE;
          end else if (in_data == ASCII_R) begin
            cpr_valid_d = 1'b1;
            cpr_row_d   = seen0 ? p0 : 8'd1;
            cpr_col_d   = seen1 ? p1 : 8'd1;
            state_d     = ST_IDLE;
          end else if (in_data >= 8'h40 && in_data <= 8'h7E) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (in_data == ASCII_ESC) begin
            err_d   = 1'b1;
            state_d = ST_ESC;
            timer_d = '0;
          end else if (in_data < 8'h30 || in_data > 8'h3F) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
          // Remaining 0x3A/0x3C..0x3F parameter bytes are tolerated and ignored.
        end
      end

      ST_SS3: begin
        if (in_valid) begin
          if (is_arrow(in_data)) begin
            key_valid_d = 1'b1;
            key_code_d  = arrow_code(in_data);
            state_d     = ST_IDLE;
          end else if (in_data == ASCII_ESC) begin
            err_d   = 1'b1;
            state_d = ST_ESC;
            timer_d = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      idx_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= KEY_NONE;
      key_char_q  <= 8'h00;
      cpr_valid_q <= 1'b0;
      cpr_row_q   <= 8'h00;
      cpr_col_q   <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_char_q  <= key_char_d;
      cpr_valid_q <= cpr_valid_d;
      cpr_row_q   <= cpr_row_d;
      cpr_col_q   <= cpr_col_d;
      err_q       <= err_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_char  = key_char_q;
  assign cpr_valid = cpr_valid_q;
  assign cpr_row   = cpr_row_q;
  assign cpr_col   = cpr_col_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ansi_input_decoder.sv
// Directed plus random byte-stream bench for ansi_input_decoder; a string-level
// reference model predicts every output on every cycle.
module tb_ansi_input_decoder;

  localparam int ESC_TIMEOUT = 4;
  localparam int PARAM_MAX   = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       key_valid;
  logic [2:0] key_code;
  logic [7:0] key_char;
  logic       cpr_valid;
  logic [7:0] cpr_row;
  logic [7:0] cpr_col;
  logic       err;

  int errors = 0;
  int checks = 0;

  ansi_input_decoder #(.ESC_TIMEOUT(ESC_TIMEOUT), .PARAM_MAX(PARAM_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_char  (key_char),
    .cpr_valid (cpr_valid),
    .cpr_row   (cpr_row),
    .cpr_col   (cpr_col),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the text of the sequence after its leading ESC.
  logic [7:0] seq[$];
  logic [7:0] stim[$];
  bit         in_seq = 1'b0;
  int         idle_cnt = 0;
  logic [7:0] m_row = 8'h00, m_col = 8'h00;
  logic       e_kv, e_cv, e_err;
  logic [2:0] e_kc;
  logic [7:0] e_kch;

  task automatic model_reset();
    in_seq = 1'b0;
    seq.delete();
    idle_cnt = 0;
    m_row = 8'h00;
    m_col = 8'h00;
    e_kv = 0; e_kc = 0; e_kch = 0; e_cv = 0; e_err = 0;
  endtask

  task automatic key(input logic [2:0] code, input logic [7:0] ch);
    e_kv = 1'b1;
    e_kc = code;
    e_kch = ch;
  endtask

  task automatic report_cpr();
    int val[2];
    bit seen[2];
    int f;
    val[0] = 0; val[1] = 0; seen[0] = 0; seen[1] = 0; f = 0;
    for (int i = 1; i < seq.size(); i++) begin
      if (seq[i] == 8'h3B) f = 1;
      else if (seq[i] >= 8'h30 && seq[i] <= 8'h39) begin
        val[f] = val[f] * 10 + int'(seq[i]) - 48;
        if (val[f] > PARAM_MAX) val[f] = PARAM_MAX;
        seen[f] = 1'b1;
      end
    end
    e_cv = 1'b1;
    m_row = seen[0] ? 8'(val[0]) : 8'd1;
    m_col = seen[1] ? 8'(val[1]) : 8'd1;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    int semis;
    e_kv = 0; e_kc = 0; e_kch = 0; e_cv = 0; e_err = 0;
    if (!in_seq) begin
      if (!v) return;
      if (b == 8'h1B) begin in_seq = 1'b1; seq.delete(); idle_cnt = 0; end
      else if (b == 8'h20) key(3'd1, b);
      else if (b >= 8'h21 && b <= 8'h7E) key(3'd7, b);
      return;
    end
    if (seq.size() == 0) begin
      if (!v) begin
        idle_cnt++;
        if (idle_cnt == ESC_TIMEOUT) begin key(3'd6, 8'h00); in_seq = 1'b0; end
        return;
      end
      if (b == 8'h5B || b == 8'h4F) seq.push_back(b);
      else if (b == 8'h1B) begin key(3'd6, 8'h00); idle_cnt = 0; end
      else begin key(3'd6, 8'h00); e_err = 1'b1; in_seq = 1'b0; end
      return;
    end
    if (!v) return;
    if (seq[0] == 8'h4F) begin
      if (b >= 8'h41 && b <= 8'h44) begin key(3'(int'(b) - 8'h41 + 2), 8'h00); in_seq = 1'b0; end
      else if (b == 8'h1B) begin e_err = 1'b1; seq.delete(); idle_cnt = 0; end
      else begin e_err = 1'b1; in_seq = 1'b0; end
      return;
    end
    semis = 0;
    foreach (seq[i]) if (seq[i] == 8'h3B) semis++;
    if (b >= 8'h40 && b <= 8'h7E) begin
      if (b >= 8'h41 && b <= 8'h44) key(3'(int'(b) - 8'h41 + 2), 8'h00);
      else if (b == 8'h52) report_cpr();
      else e_err = 1'b1;
      in_seq = 1'b0;
    end else if (b == 8'h3B && semis >= 1) begin
      e_err = 1'b1; in_seq = 1'b0;
    end else if (b >= 8'h30 && b <= 8'h3F) begin
      seq.push_back(b);
    end else if (b == 8'h1B) begin
      e_err = 1'b1; seq.delete(); idle_cnt = 0;
    end else begin
      e_err = 1'b1; in_seq = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input string tag);
    in_valid = v;
    in_data = b;
    @(posedge clk);
    #1;
    model_step(v, b);
    chk($sformatf("%s v=%0b b=%h", tag, v, b),
        {2'b0, key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err},
        {2'b0, e_kv, e_kc, e_kch, e_cv, m_row, m_col, e_err});
    $display("txn %-10s v=%0b b=%h kv=%0b kc=%0d kch=%h cv=%0b row=%0d col=%0d err=%0b",
             tag, v, b, key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err);
    in_valid = 1'b0;
  endtask

  task automatic play(input string tag);
    while (stim.size() > 0) cyc(1'b1, stim.pop_front(), tag);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 14) return 8'h1B;
    if (r < 24) return 8'h5B;
    if (r < 29) return 8'h4F;
    if (r < 49) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 57) return 8'h3B;
    if (r < 69) return 8'(8'h41 + $urandom_range(0, 3));
    if (r < 75) return 8'h52;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {2'b0, key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err}, 32'h0);
    rst_n = 1'b1;

    stim = '{8'h20, 8'h71};
    play("space_q");
    chk("q_char", {21'h0, key_code, key_char}, {21'h0, 3'd7, 8'h71});

    stim = '{8'h1B, 8'h5B, 8'h41, 8'h1B, 8'h4F, 8'h42};
    play("arrows");
    chk("ss3_down", {28'h0, key_valid, key_code}, {28'h0, 1'b1, 3'd3});

    stim = '{8'h1B, 8'h5B, 8'h32, 8'h34, 8'h3B, 8'h38, 8'h30, 8'h52};
    play("cpr_24_80");
    chk("cpr_24_80", {15'h0, cpr_valid, cpr_row, cpr_col}, {15'h0, 1'b1, 8'd24, 8'd80});
    stim = '{8'h1B, 8'h5B, 8'h52};
    play("cpr_dflt");
    chk("cpr_dflt", {15'h0, cpr_valid, cpr_row, cpr_col}, {15'h0, 1'b1, 8'd1, 8'd1});

    cyc(1'b1, 8'h1B, "lone_esc");
    repeat (ESC_TIMEOUT - 1) cyc(1'b0, 8'h5B, "esc_idle");
    chk("esc_not_yet", {31'h0, key_valid}, 32'h0);
    cyc(1'b0, 8'h00, "esc_tmo");
    chk("esc_timeout", {28'h0, key_valid, key_code}, {28'h0, 1'b1, 3'd6});
    stim = '{8'h1B, 8'h1B, 8'h5B, 8'h43};
    play("esc_esc");
    chk("esc_right", {28'h0, key_valid, key_code}, {28'h0, 1'b1, 3'd4});

    stim = '{8'h1B, 8'h5B, 8'h39, 8'h39, 8'h39, 8'h3B, 8'h35, 8'h52};
    play("cpr_sat");
    chk("cpr_sat", {16'h0, cpr_row, cpr_col}, {16'h0, 8'd255, 8'd5});
    stim = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h32, 8'h3B};
    play("semi2");
    chk("semi2_err", {31'h0, err}, 32'h1);
    stim = '{8'h33, 8'h52};
    play("after_err");
    chk("after_err_R", {20'h0, key_valid, key_code, key_char}, {20'h0, 1'b1, 3'd7, 8'h52});

    stim = '{8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h52};
    play("cpr_zero");
    chk("cpr_zero", {16'h0, cpr_row, cpr_col}, {16'h0, 8'd0, 8'd0});

    stim = '{8'h1B, 8'h5B, 8'h31};
    play("pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", {2'b0, key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h41, "post_rst");
    chk("post_rst_char", {20'h0, key_valid, key_code, key_char}, {20'h0, 1'b1, 3'd7, 8'h41});

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) cyc(1'b1, rand_byte(), "random");
      else cyc(1'b0, 8'($urandom_range(0, 255)), "rand_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
